// File: rtl/hazard_ctrl_if.sv
//==============================================================================
// hazard_ctrl_if : datapath <-> hazard controller signal bundle
// Rev 1.0
//==============================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       MemAccessD;
  logic       PCSrcE;
  logic       mem_ready;

  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       mem_req;
  logic       mem_err;
  logic [15:0] stall_cnt;

  // Datapath side
  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD, PCSrcE, mem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  ForwardAE, ForwardBE, mem_req, mem_err, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD, PCSrcE, mem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
    output ForwardAE, ForwardBE, mem_req, mem_err, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//==============================================================================
// hazard_ctrl : RV32I hazard controller - shadow E/M/W tags, stall/flush,
//               forwarding selects and data-memory wait FSM with watchdog
// Rev 1.0
//==============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned c_sat_w     = (WIDTH < 16) ? ((WIDTH < 1) ? 1 : WIDTH) : 16;
  localparam logic [15:0] c_stall_max = 16'hFFFF >> (16 - c_sat_w);
  localparam logic [7:0]  c_timeout   = 8'(TIMEOUT);
  localparam logic [1:0]  c_fwd_rf    = 2'b00;
  localparam logic [1:0]  c_fwd_wb    = 2'b01;
  localparam logic [1:0]  c_fwd_mem   = 2'b10;
  localparam logic [1:0]  c_src_load  = 2'b01;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [4:0]  e_rs1_q, e_rs1_d;
  logic [4:0]  e_rs2_q, e_rs2_d;
  logic [4:0]  e_rd_q, e_rd_d;
  logic        e_regwrite_q, e_regwrite_d;
  logic        e_isload_q, e_isload_d;
  logic        e_memaccess_q, e_memaccess_d;
  logic [4:0]  m_rd_q, m_rd_d;
  logic        m_regwrite_q, m_regwrite_d;
  logic        m_memaccess_q, m_memaccess_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;

  logic        freeze;
  logic        load_use;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e;
  logic [1:0]  fwd_a, fwd_b;

  // Memory wait FSM; a watchdog abort releases the freeze like mem_ready would
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (m_memaccess_q && !bus.mem_ready) begin
          freeze     = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (bus.mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_d >= c_timeout) begin
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
        end else begin
          freeze = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stall/flush priority: memory freeze > taken branch > load-use
  always_comb begin
    load_use = e_isload_q && (e_rd_q != 5'd0) &&
               ((e_rd_q == bus.Rs1D) || (e_rd_q == bus.Rs2D));
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    fwd_a = c_fwd_rf;
    fwd_b = c_fwd_rf;
    if (m_regwrite_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs1_q)) begin
      fwd_a = c_fwd_mem;
    end else if (wb_regwrite_q && (wb_rd_q != 5'd0) && (wb_rd_q == e_rs1_q)) begin
      fwd_a = c_fwd_wb;
    end
    if (m_regwrite_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs2_q)) begin
      fwd_b = c_fwd_mem;
    end else if (wb_regwrite_q && (wb_rd_q != 5'd0) && (wb_rd_q == e_rs2_q)) begin
      fwd_b = c_fwd_wb;
    end
  end

  // Shadow pipeline: frozen cycles hold E/M and drain a bubble into W
  always_comb begin
    e_rs1_d       = e_rs1_q;
    e_rs2_d       = e_rs2_q;
    e_rd_d        = e_rd_q;
    e_regwrite_d  = e_regwrite_q;
    e_isload_d    = e_isload_q;
    e_memaccess_d = e_memaccess_q;
    m_rd_d        = m_rd_q;
    m_regwrite_d  = m_regwrite_q;
    m_memaccess_d = m_memaccess_q;
    wb_rd_d       = 5'd0;
    wb_regwrite_d = 1'b0;
    if (!freeze) begin
      if (flush_e) begin
        e_rs1_d       = 5'd0;
        e_rs2_d       = 5'd0;
        e_rd_d        = 5'd0;
        e_regwrite_d  = 1'b0;
        e_isload_d    = 1'b0;
        e_memaccess_d = 1'b0;
      end else begin
        e_rs1_d       = bus.Rs1D;
        e_rs2_d       = bus.Rs2D;
        e_rd_d        = bus.RdD;
        e_regwrite_d  = bus.RegWriteD;
        e_isload_d    = (bus.ResultSrcD == c_src_load);
        e_memaccess_d = bus.MemAccessD;
      end
      m_rd_d        = e_rd_q;
      m_regwrite_d  = e_regwrite_q;
      m_memaccess_d = e_memaccess_q;
      wb_rd_d       = m_rd_q;
      wb_regwrite_d = m_regwrite_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != c_stall_max)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_err_q     <= 1'b0;
      stall_cnt_q   <= 16'd0;
      e_rs1_q       <= 5'd0;
      e_rs2_q       <= 5'd0;
      e_rd_q        <= 5'd0;
      e_regwrite_q  <= 1'b0;
      e_isload_q    <= 1'b0;
      e_memaccess_q <= 1'b0;
      m_rd_q        <= 5'd0;
      m_regwrite_q  <= 1'b0;
      m_memaccess_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_cnt_q   <= stall_cnt_d;
      e_rs1_q       <= e_rs1_d;
      e_rs2_q       <= e_rs2_d;
      e_rd_q        <= e_rd_d;
      e_regwrite_q  <= e_regwrite_d;
      e_isload_q    <= e_isload_d;
      e_memaccess_q <= e_memaccess_d;
      m_rd_q        <= m_rd_d;
      m_regwrite_q  <= m_regwrite_d;
      m_memaccess_q <= m_memaccess_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
    end
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.ForwardAE = fwd_a;
  assign bus.ForwardBE = fwd_b;
  assign bus.mem_req   = m_memaccess_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. Tracks destination/source register tags for the Execute, Memory and Writeback stages in its own shadow pipeline. Generates per-stage stall/flush strobes and Execute-stage forwarding selects. Sequences data-memory wait states through a small FSM with a timeout watchdog. Sits beside the datapath; the Fetch, Decode, Execute and Memory pipeline registers consume its stall and flush outputs.

## Interface
Parameters:
- WIDTH, 32, datapath width (used only for stall counter saturation guard consistency; counter is 16 bits)
- TIMEOUT, 255, maximum consecutive WAIT cycles before watchdog abort

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- Rs1D, Rs2D  in  5  Decode-stage source register indices
- RdD  in  5  Decode-stage destination index
- RegWriteD  in  1  Decode instruction writes the register file
- ResultSrcD  in  2  Decode result select; 2'b01 means load
- MemAccessD  in  1  Decode instruction is a load or store
- PCSrcE  in  1  taken branch/jump resolved in Execute
- mem_ready  in  1  data memory completes the Memory-stage access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the respective pipeline register
- FlushD, FlushE  out  1  load a bubble into the respective pipeline register
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- mem_req  out  1  Memory-stage access pending
- mem_err  out  1  sticky watchdog-abort flag
- stall_cnt  out  16  saturating count of cycles with StallF asserted

## Operation
- Shadow stages: E {rs1, rs2, rd, regwrite, isload, memaccess}, M {rd, regwrite, memaccess}, W {rd, regwrite}. On reset all fields are 0, so every stage holds a bubble.
- Advance on each clk edge when not frozen: D→E (zeros if FlushE), E→M, M→W.
- Frozen cycles: E and M hold their contents and W loads a bubble.
- Forwarding for ForwardAE, with the same rule for ForwardBE using rs2:
  - 10 if M.regwrite, M.rd≠0 and M.rd==E.rs1;
  - else 01 if W.regwrite, W.rd≠0 and W.rd==E.rs1;
  - else 00.
  - M takes priority over W.
- Load-use hazard: condition is E.isload, E.rd≠0 and E.rd ∈ {Rs1D, Rs2D}. Response is StallF=StallD=1 and FlushE=1. x0 never triggers the hazard.
- Control hazard: PCSrcE=1 drives FlushD=FlushE=1. StallF and StallD are forced to 0 so the target PC loads.
- Priority, highest first: memory freeze > PCSrcE > load-use.
- Memory FSM states: RUN, WAIT.
  - RUN: if M.memaccess and !mem_ready, go to WAIT and freeze in the same cycle (combinational). Otherwise stay in RUN.
  - WAIT: freeze. If mem_ready, go to RUN; the freeze is released in that same cycle.
  - Watchdog: if the wait counter reaches TIMEOUT, go to RUN and set mem_err. The M access is then treated as complete.
  - Freeze means StallF=StallD=StallE=StallM=1, FlushD=FlushE=0. A PCSrcE or load-use condition that is pending during the freeze is acted on in the first unfrozen cycle.
- mem_req = M.memaccess, independent of state. It is deasserted when M advances.
- Wait counter: 8 bits. Cleared on entry to WAIT, incremented each WAIT cycle.
- mem_err: cleared only by rst.
- stall_cnt: increments in every cycle with StallF=1 and saturates at 16'hFFFF.

## Timing
- Reset values: all stall and flush outputs 0, Forward* 00, mem_req 0, mem_err 0, stall_cnt 0, FSM in RUN.
- Stall, flush and forward outputs are combinational from the current shadow state and inputs, with zero-cycle latency. Registered state changes only on the clk rising edge.
- A load-use stall lasts exactly 1 cycle: the next edge moves a bubble into E, so the condition clears.
- Branch flush lasts 1 cycle. Two wrong-path instructions are discarded.
- If mem_ready arrives in the same cycle the access reaches M, there is no freeze and 0 penalty.
- Reset asserted mid-WAIT returns the FSM to RUN immediately and clears all shadow state.
- The watchdog exits after exactly TIMEOUT WAIT cycles. mem_err is high from the following cycle onward.

## Test plan
- ALU forwarding: issue add x5 followed by sub using x5 as rs1, with no memory. Required response when sub is in E: ForwardAE=10 and no stall.
- W-stage forward: issue add x5, then nop, then an instruction using x5 as rs2. Required response: ForwardBE=01.
- Load-use: issue lw x6 followed by add using x6 as rs1. Required response: StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01. Repeat with rd=x0: no stall.
- Branch with simultaneous load-use: PCSrcE=1 together with a load-use condition. Required response: FlushD=FlushE=1 and StallF=0.
- Memory wait: hold mem_ready=0 for 3 cycles while a store is in M. Required response: all four Stall*=1 for 3 cycles, mem_req=1 throughout, stall_cnt=3, and resume on the mem_ready cycle.
- Watchdog and reset: set TIMEOUT=4 and never assert mem_ready. Required response: RUN after 4 cycles and mem_err=1. Then pulse rst mid-WAIT: all outputs return to their reset values at once.
